text_console_writer: RTL and testbench

TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

---
 rtl/text_console_writer_pkg.sv | 24 ++
 rtl/text_console_writer.sv | 186 ++++++++++++++++++
 tb/tb_text_console_writer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_console_writer_pkg.sv
// Shared definitions for the text console writer: control-byte codes and FSM states.
package text_console_writer_pkg;

   localparam logic [7:0] ASCII_BS    = 8'h08;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_FF    = 8'h0C;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_TILDE = 8'h7E;

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_WRITE,
      ST_SCR_RD,
      ST_SCR_WR,
      ST_SCR_CLR
   } state_t;

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= ASCII_SPACE) && (b <= ASCII_TILDE);
   endfunction

endpackage

// File: rtl/text_console_writer.sv
// Turns a keyboard byte stream into text-RAM writes plus cursor position; handles CR/LF/BS/FF, scroll, clear.
// One byte per 2 cycles when printable; char_ready drops while writing, scrolling or clearing.
module text_console_writer
   import text_console_writer_pkg::*;
#(
   parameter int COLS           = 80,
   parameter int ROWS           = 40,
   parameter int ADDR_W         = 12,
   parameter int SCROLL_EN      = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              char_valid,
   input  logic [7:0]        char_data,
   output logic              char_ready,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_din,
   input  logic [7:0]        ram_dout,
   output logic [7:0]        cursor_x,
   output logic [7:0]        cursor_y,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] CELL_LAST     = ADDR_W'(COLS * ROWS - 1);
   localparam logic [ADDR_W-1:0] ROW_LAST_BASE = ADDR_W'((ROWS - 1) * COLS);
   localparam logic [ADDR_W-1:0] COLS_A        = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] COLS_P1       = ADDR_W'(COLS + 1);
   localparam logic [ADDR_W-1:0] ONE_A         = ADDR_W'(1);
   localparam logic [7:0]        X_MAX         = 8'(COLS - 1);
   localparam logic [7:0]        Y_MAX         = 8'(ROWS - 1);
   localparam state_t            RESET_ST      = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
   localparam state_t            SCROLL_ENTRY  = (ROWS == 1) ? ST_SCR_CLR : ST_SCR_RD;

   state_t            state_q, state_d;
   logic [7:0]        x_q, x_d, y_q, y_d;
   logic [ADDR_W-1:0] lin_q, lin_d, a_q, a_d, addr_q, addr_d;
   logic [7:0]        din_q, din_d;
   logic              first_q, first_d, pend_q, pend_d;
   logic              we_q, we_d, ready_q, ready_d, busy_q, busy_d;

   logic accept, at_last_col, at_last_row, at_origin, scroll_start;

   assign accept       = char_valid && ready_q;
   assign at_last_col  = (x_q == X_MAX);
   assign at_last_row  = (y_q == Y_MAX);
   assign at_origin    = (x_q == 8'd0) && (y_q == 8'd0);
   assign scroll_start = ((state_q == ST_IDLE) || (state_q == ST_WRITE)) &&
                         ((state_d == ST_SCR_RD) || (state_d == ST_SCR_CLR));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= RESET_ST;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CLEAR:   if (!first_q && a_q == CELL_LAST) state_d = ST_IDLE;
         ST_IDLE: begin
            if (accept) begin
               if (is_printable(char_data) || (char_data == ASCII_BS && !at_origin))
                  state_d = ST_WRITE;
               else if (char_data == ASCII_FF)
                  state_d = ST_CLEAR;
               else if (char_data == ASCII_LF && at_last_row && SCROLL_EN != 0)
                  state_d = SCROLL_ENTRY;
            end
         end
         ST_WRITE:   state_d = pend_q ? SCROLL_ENTRY : ST_IDLE;
         ST_SCR_RD:  state_d = ST_SCR_WR;
         ST_SCR_WR:  state_d = (a_q == CELL_LAST) ? ST_SCR_CLR : ST_SCR_RD;
         ST_SCR_CLR: if (a_q == CELL_LAST) state_d = ST_IDLE;
         default:    state_d = RESET_ST;
      endcase
   end

   always_comb begin
      x_d = x_q;  y_d = y_q;  lin_d = lin_q;  a_d = a_q;
      addr_d = addr_q;  din_d = din_q;  first_d = first_q;  pend_d = pend_q;
      we_d = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            // first cycle out of reset only primes the write of cell 0
            if (first_q) begin
               first_d = 1'b0;  we_d = 1'b1;  addr_d = '0;  din_d = ASCII_SPACE;
            end else if (a_q == CELL_LAST) begin
               x_d = 8'd0;  y_d = 8'd0;  lin_d = '0;
            end else begin
               a_d = a_q + ONE_A;  addr_d = a_q + ONE_A;  we_d = 1'b1;  din_d = ASCII_SPACE;
            end
         end
         ST_IDLE: begin
            if (accept) begin
               if (is_printable(char_data)) begin
                  we_d = 1'b1;  addr_d = lin_q;  din_d = char_data;
                  if (!at_last_col) begin
                     x_d = x_q + 8'd1;  lin_d = lin_q + ONE_A;
                  end else if (!at_last_row) begin
                     x_d = 8'd0;  y_d = y_q + 8'd1;  lin_d = lin_q + ONE_A;
                  end else if (SCROLL_EN != 0) begin
                     x_d = 8'd0;  y_d = Y_MAX;  lin_d = ROW_LAST_BASE;  pend_d = 1'b1;
                  end else begin
                     x_d = 8'd0;  y_d = 8'd0;  lin_d = '0;
                  end
               end else if (char_data == ASCII_BS) begin
                  if (!at_origin) begin
                     we_d = 1'b1;  addr_d = lin_q - ONE_A;  din_d = ASCII_SPACE;
                     lin_d = lin_q - ONE_A;
                     if (x_q == 8'd0) begin
                        x_d = X_MAX;  y_d = y_q - 8'd1;
                     end else begin
                        x_d = x_q - 8'd1;
                     end
                  end
               end else if (char_data == ASCII_CR) begin
                  x_d = 8'd0;  lin_d = lin_q - ADDR_W'(x_q);
               end else if (char_data == ASCII_LF) begin
                  x_d = 8'd0;
                  if (!at_last_row) begin
                     y_d = y_q + 8'd1;  lin_d = lin_q - ADDR_W'(x_q) + COLS_A;
                  end else if (SCROLL_EN != 0) begin
                     y_d = Y_MAX;  lin_d = ROW_LAST_BASE;
                  end else begin
                     y_d = 8'd0;  lin_d = '0;
                  end
               end else if (char_data == ASCII_FF) begin
                  a_d = '0;  first_d = 1'b0;  we_d = 1'b1;  addr_d = '0;  din_d = ASCII_SPACE;
               end
            end
         end
         // The write in SCR_WR carries the cell read one slot earlier; din_q holds it meanwhile.
         ST_SCR_RD: begin
            if (!first_q) begin
               we_d = 1'b1;  addr_d = a_q - COLS_P1;
            end
         end
         ST_SCR_WR: begin
            din_d = ram_dout;  first_d = 1'b0;
            if (a_q == CELL_LAST) begin
               a_d = CELL_LAST - COLS_A;  addr_d = CELL_LAST - COLS_A;  we_d = 1'b1;
            end else begin
               a_d = a_q + ONE_A;  addr_d = a_q + ONE_A;
            end
         end
         ST_SCR_CLR: begin
            if (a_q != CELL_LAST) begin
               a_d = a_q + ONE_A;  addr_d = a_q + ONE_A;  we_d = 1'b1;  din_d = ASCII_SPACE;
            end
         end
         default: ;
      endcase
      if (scroll_start) begin
         pend_d  = 1'b0;
         first_d = 1'b1;
         a_d     = (ROWS == 1) ? '0 : COLS_A;
         addr_d  = (ROWS == 1) ? '0 : COLS_A;
         we_d    = (ROWS == 1);
         din_d   = ASCII_SPACE;
      end
      ready_d = (state_d == ST_IDLE);
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q <= 8'd0;  y_q <= 8'd0;  lin_q <= '0;  a_q <= '0;
         addr_q <= '0;  din_q <= 8'd0;  first_q <= 1'b1;  pend_q <= 1'b0;
         we_q <= 1'b0;  ready_q <= 1'b0;  busy_q <= 1'b1;
      end else begin
         x_q <= x_d;  y_q <= y_d;  lin_q <= lin_d;  a_q <= a_d;
         addr_q <= addr_d;  din_q <= din_d;  first_q <= first_d;  pend_q <= pend_d;
         we_q <= we_d;  ready_q <= ready_d;  busy_q <= busy_d;
      end
   end

   assign char_ready = ready_q;
   assign ram_we     = we_q;
   assign ram_addr   = addr_q;
   assign ram_din    = din_q;
   assign cursor_x   = x_q;
   assign cursor_y   = y_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: default console plus a non-scrolling, no-clear variant.
module tb_text_console_writer;
   import text_console_writer_pkg::*;

   typedef struct packed { logic [11:0] a; logic [7:0] d; } wr_t;
   typedef struct { logic [7:0] ch; bit wr; int a; logic [7:0] d; int x; int y; } vec_t;

   logic clk = 1'b0;
   always #20 clk = ~clk;

   logic rst0, rst1, cv0, cv1;
   logic [7:0] cd;
   logic rdy0, we0, busy0, rdy1, we1, busy1;
   logic [11:0] addr0, addr1;
   logic [7:0] din0, dout0, cx0, cy0, din1, dout1, cx1, cy1;

   text_console_writer dut0 (
      .clk(clk), .reset(rst0), .char_valid(cv0), .char_data(cd), .char_ready(rdy0),
      .ram_we(we0), .ram_addr(addr0), .ram_din(din0), .ram_dout(dout0),
      .cursor_x(cx0), .cursor_y(cy0), .busy(busy0));

   text_console_writer #(.SCROLL_EN(0), .CLEAR_ON_RESET(0)) dut1 (
      .clk(clk), .reset(rst1), .char_valid(cv1), .char_data(cd), .char_ready(rdy1),
      .ram_we(we1), .ram_addr(addr1), .ram_din(din1), .ram_dout(dout1),
      .cursor_x(cx1), .cursor_y(cy1), .busy(busy1));

   logic [7:0] mem0 [0:4095];
   logic [7:0] mem1 [0:4095];
   logic bd_en;
   logic [11:0] bd_a;
   logic [7:0] bd_d;
   always @(posedge clk) begin
      if (bd_en) mem0[bd_a] <= bd_d;
      else if (we0) mem0[addr0] <= din0;
      dout0 <= mem0[addr0];
      if (we1) mem1[addr1] <= din1;
      dout1 <= mem1[addr1];
   end

   int errors = 0, checks = 0;
   bit sel = 1'b0, sb0_on = 1'b1;
   wr_t q0[$], q1[$];
   wr_t e0, e1;
   logic [7:0] shadow [0:3199];
   vec_t tbl [14];

   logic rdy, busy_m;
   logic [7:0] cx, cy;
   assign rdy    = sel ? rdy1 : rdy0;
   assign busy_m = sel ? busy1 : busy0;
   assign cx     = sel ? cx1 : cx0;
   assign cy     = sel ? cy1 : cy0;

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   function automatic wr_t mk(input int a, input logic [7:0] d);
      wr_t w;
      w.a = 12'(a);
      w.d = d;
      return w;
   endfunction

   function automatic logic [7:0] pat(input int i);
      return 8'(33 + (i * 7) % 90);
   endfunction

   always @(negedge clk) begin
      if (we0 === 1'b1 && sb0_on) begin
         if (q0.size() == 0) chk(1'b0, "dut0_unexpected_write", int'({addr0, din0}), 0);
         else begin
            e0 = q0.pop_front();
            chk({addr0, din0} == {e0.a, e0.d}, "dut0_write", int'({addr0, din0}), int'({e0.a, e0.d}));
         end
      end
      if (we1 === 1'b1) begin
         if (q1.size() == 0) chk(1'b0, "dut1_unexpected_write", int'({addr1, din1}), 0);
         else begin
            e1 = q1.pop_front();
            chk({addr1, din1} == {e1.a, e1.d}, "dut1_write", int'({addr1, din1}), int'({e1.a, e1.d}));
         end
      end
   end

   task automatic wait_ready(input int limit, input string name);
      int n = 0;
      while (rdy !== 1'b1 && n < limit) begin @(posedge clk); #1; n++; end
      if (rdy !== 1'b1) chk(1'b0, name, n, limit);
   endtask

   task automatic send(input logic [7:0] b, input bit wr);
      wait_ready(20000, "ready_timeout");
      if (sel) cv1 = 1'b1; else cv0 = 1'b1;
      cd = b;
      @(posedge clk); #1;
      cv0 = 1'b0; cv1 = 1'b0;
      if (wr) begin
         chk(rdy === 1'b0, "ready_low_after_accept", int'(rdy), 0);
         @(posedge clk); #1;
         chk(rdy === 1'b1, "ready_back_after_write", int'(rdy), 1);
      end
   endtask

   task automatic chk_cursor(input string name, input int x, input int y);
      chk(int'(cx) == x && int'(cy) == y, name, int'({cx, cy}), (x << 8) | y);
   endtask

   initial begin : watchdog
      #(40 * 60000);
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   initial begin : stim
      int n, mism;
      rst0 = 1'b1; rst1 = 1'b1; cv0 = 1'b0; cv1 = 1'b0; cd = 8'h00;
      bd_en = 1'b0; bd_a = '0; bd_d = '0;

      tbl[0]  = '{8'h41, 1'b1, 0,  8'h41, 1,  0};
      tbl[1]  = '{8'h42, 1'b1, 1,  8'h42, 2,  0};
      tbl[2]  = '{8'h0D, 1'b0, 0,  8'h00, 0,  0};
      tbl[3]  = '{8'h0A, 1'b0, 0,  8'h00, 0,  1};
      tbl[4]  = '{8'h43, 1'b1, 80, 8'h43, 1,  1};
      tbl[5]  = '{8'h08, 1'b1, 80, 8'h20, 0,  1};
      tbl[6]  = '{8'h08, 1'b1, 79, 8'h20, 79, 0};
      tbl[7]  = '{8'h01, 1'b0, 0,  8'h00, 79, 0};
      tbl[8]  = '{8'hFF, 1'b0, 0,  8'h00, 79, 0};
      tbl[9]  = '{8'h7E, 1'b1, 79, 8'h7E, 0,  1};
      tbl[10] = '{8'h0D, 1'b0, 0,  8'h00, 0,  1};
      tbl[11] = '{8'h7F, 1'b0, 0,  8'h00, 0,  1};
      tbl[12] = '{8'h20, 1'b1, 80, 8'h20, 1,  1};
      tbl[13] = '{8'h0A, 1'b0, 0,  8'h00, 0,  2};

      repeat (3) @(posedge clk);
      #1;
      chk(we0 == 1'b0, "rst_we", int'(we0), 0);
      chk(addr0 == 12'd0, "rst_addr", int'(addr0), 0);
      chk(din0 == 8'd0, "rst_din", int'(din0), 0);
      chk(cx0 == 8'd0 && cy0 == 8'd0, "rst_cursor", int'({cx0, cy0}), 0);
      chk(rdy0 == 1'b0, "rst_ready", int'(rdy0), 0);
      chk(busy0 == 1'b1, "rst_busy", int'(busy0), 1);
      chk(rdy1 == 1'b0 && busy1 == 1'b1, "rst_dut1", int'({rdy1, busy1}), 1);

      // power-up clear of the whole screen
      for (int a = 0; a < 3200; a++) q0.push_back(mk(a, 8'h20));
      @(negedge clk);
      rst0 = 1'b0; rst1 = 1'b0;
      @(posedge clk); #1;
      chk(busy0 == 1'b1, "clear_busy", int'(busy0), 1);
      wait_ready(5000, "clear_timeout");
      chk(q0.size() == 0, "clear_writes_left", q0.size(), 0);
      chk_cursor("clear_cursor", 0, 0);
      chk(rdy1 == 1'b1 && busy1 == 1'b0, "dut1_no_clear", int'({rdy1, busy1}), 2);

      foreach (tbl[i]) begin
         if (tbl[i].wr) q0.push_back(mk(tbl[i].a, tbl[i].d));
         send(tbl[i].ch, tbl[i].wr);
         chk(q0.size() == 0, $sformatf("vec%0d_write", i), q0.size(), 0);
         chk_cursor($sformatf("vec%0d_cursor", i), tbl[i].x, tbl[i].y);
      end

      // form feed, then backspace at the origin is a no-op
      for (int a = 0; a < 3200; a++) q0.push_back(mk(a, 8'h20));
      send(ASCII_FF, 1'b0);
      chk(busy0 == 1'b1, "ff_busy", int'(busy0), 1);
      wait_ready(5000, "ff_timeout");
      chk(q0.size() == 0, "ff_writes_left", q0.size(), 0);
      chk_cursor("ff_cursor", 0, 0);
      send(ASCII_BS, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk_cursor("bs_origin_cursor", 0, 0);
      chk(rdy0 == 1'b1, "bs_origin_ready", int'(rdy0), 1);

      // backspace from column 0 wraps to previous row
      repeat (5) send(ASCII_LF, 1'b0);
      chk_cursor("lf5_cursor", 0, 5);
      q0.push_back(mk(399, 8'h20));
      send(ASCII_BS, 1'b1);
      chk(q0.size() == 0, "bs_wrap_write", q0.size(), 0);
      chk_cursor("bs_wrap_cursor", 79, 4);

      // walk to the bottom-right cell
      send(ASCII_CR, 1'b0);
      repeat (35) send(ASCII_LF, 1'b0);
      chk_cursor("lf_bottom_cursor", 0, 39);
      for (int i = 0; i < 79; i++) begin
         q0.push_back(mk(3120 + i, 8'(8'h61 + i % 26)));
         send(8'(8'h61 + i % 26), 1'b1);
      end
      chk(q0.size() == 0, "row39_writes", q0.size(), 0);
      chk_cursor("pre_scroll_cursor", 79, 39);

      for (int i = 0; i < 3200; i++) begin
         bd_en = 1'b1; bd_a = 12'(i); bd_d = pat(i); shadow[i] = pat(i);
         @(posedge clk); #1;
      end
      bd_en = 1'b0;

      q0.push_back(mk(3199, 8'h5A));
      shadow[3199] = 8'h5A;
      for (int a = 80; a < 3200; a++) begin
         q0.push_back(mk(a - 80, shadow[a]));
         shadow[a - 80] = shadow[a];
      end
      for (int a = 3120; a < 3200; a++) begin
         q0.push_back(mk(a, 8'h20));
         shadow[a] = 8'h20;
      end
      send(8'h5A, 1'b0);
      chk(rdy0 == 1'b0, "scroll_ready_low", int'(rdy0), 0);
      wait_ready(20000, "scroll_timeout");
      chk(q0.size() == 0, "scroll_writes_left", q0.size(), 0);
      chk_cursor("scroll_cursor", 0, 39);
      chk(busy0 == 1'b0, "scroll_busy_done", int'(busy0), 0);
      mism = 0;
      for (int i = 0; i < 3200; i++) if (mem0[i] !== shadow[i]) mism++;
      chk(mism == 0, "scroll_ram_image", mism, 0);

      // second scroll, interrupted by reset while copying
      for (int i = 0; i < 79; i++) begin
         q0.push_back(mk(3120 + i, 8'h2E));
         send(8'h2E, 1'b1);
      end
      sb0_on = 1'b0;
      send(8'h51, 1'b0);
      repeat (300) @(posedge clk);
      #1;
      n = 0;
      while (we0 !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      chk(we0 === 1'b1, "mid_scroll_write_seen", int'(we0), 1);
      rst0 = 1'b1;
      #1;
      chk(we0 == 1'b0, "abort_we", int'(we0), 0);
      chk(cx0 == 8'd0 && cy0 == 8'd0, "abort_cursor", int'({cx0, cy0}), 0);
      chk(busy0 == 1'b1 && rdy0 == 1'b0, "abort_busy_ready", int'({busy0, rdy0}), 2);
      q0.delete();
      for (int a = 0; a < 3200; a++) q0.push_back(mk(a, 8'h20));
      sb0_on = 1'b1;
      @(negedge clk);
      rst0 = 1'b0;
      wait_ready(5000, "reclear_timeout");
      chk(q0.size() == 0, "reclear_writes_left", q0.size(), 0);
      chk_cursor("reclear_cursor", 0, 0);

      // non-scrolling variant: LF at the last cell wraps to origin silently
      sel = 1'b1;
      repeat (39) send(ASCII_LF, 1'b0);
      chk_cursor("d1_lf_cursor", 0, 39);
      for (int i = 0; i < 79; i++) begin
         q1.push_back(mk(3120 + i, 8'h30));
         send(8'h30, 1'b1);
      end
      chk_cursor("d1_pre_wrap_cursor", 79, 39);
      send(ASCII_LF, 1'b0);
      chk_cursor("d1_wrap_cursor", 0, 0);
      repeat (4) @(posedge clk);
      #1;
      chk(rdy1 == 1'b1 && busy1 == 1'b0, "d1_idle_after_wrap", int'({rdy1, busy1}), 2);
      chk(q1.size() == 0, "d1_writes_left", q1.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
